ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Multi-cycle control sequencer for the 8-bit CPU core. It steps each 16-bit instruction through the fetch, decode, execute, memory and write-back phases. It holds instruction-memory and data-memory request handshakes, latches the decoder's control flags for the life of the instruction, and gates register-file write, data-memory strobes and PC update. It sits between the instruction decoder, ALU, register file, PC register and the two memory ports.

## Interface
- `MEM_TIMEOUT`, default 15: maximum wait cycles on a memory handshake before abort (1..255).
- `CNT_W`, default 16: width of the retired-instruction counter.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `run` input 1: start execution from IDLE (level).
- `halt_req` input 1: request stop after the current instruction (sampled every cycle).
- `im_ready` input 1: instruction memory returns data this cycle.
- `dm_ready` input 1: data memory completes the access this cycle.
- `Branch`, `Mem2Reg`, `RF_w_en`, `DM_w_en`, `DM_r_en`, `is_jal` input 1 each: decoder flags for the current IR.
- `alu_zero_taken` input 1: ALU branch-condition result, valid in EXEC.
- `im_req` output 1: instruction fetch request.
- `ir_en` output 1: load the instruction register.
- `alu_en` output 1: ALU operand/result capture strobe.
- `dm_req`, `dm_we`, `dm_re` output 1 each: data-memory request and direction.
- `rf_we` output 1: register-file write strobe.
- `wb_sel_mem` output 1: write-back source is memory, driven from latched `Mem2Reg`.
- `pc_en` output 1: PC update strobe.
- `pc_sel` output 1: 1 selects the branch/jump target, 0 selects PC+1.
- `busy` output 1: high in any state other than IDLE.
- `bus_err` output 1: one-cycle pulse on handshake timeout.
- `state` output 3: current state encoding (observability).
- `instret` output CNT_W: count of retired instructions.

## Operation
- States, with fixed encodings: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5. Codes 6 and 7 go to IDLE on the next clock.
- IDLE:
  - All strobes are 0.
  - With `run`=1, go to FETCH.
  - Entering IDLE clears the halt latch.
- FETCH:
  - `im_req`=1 is held.
  - `ir_en` = `im_ready` (Mealy output, same cycle).
  - On `im_ready`, go to DECODE and clear the wait counter.
- DECODE:
  - Latch all six decoder flags into `ctl_q`.
  - Go to EXEC.
- EXEC:
  - `alu_en`=1.
  - Set `taken_q` = `is_jal_q` | (`Branch_q` & `alu_zero_taken`).
  - If `DM_r_en_q` | `DM_w_en_q`, go to MEM; otherwise go to WB.
- MEM:
  - `dm_req`=1, `dm_we`=`DM_w_en_q`, `dm_re`=`DM_r_en_q`, all held stable until `dm_ready`.
  - On `dm_ready`, go to WB.
- WB:
  - `rf_we`=`RF_w_en_q`, `wb_sel_mem`=`Mem2Reg_q`, `pc_en`=1, `pc_sel`=`taken_q`.
  - Increment `instret` (wraps modulo 2^CNT_W).
  - If the halt latch is set, go to IDLE; otherwise go to FETCH.
- Halt latch:
  - Set by `halt_req`=1 in any non-IDLE state.
  - The in-flight instruction always retires. `halt_req` never aborts a phase.
- Timeout:
  - An 8-bit wait counter increments each cycle in FETCH or MEM while ready=0.
  - When the counter equals MEM_TIMEOUT with ready still 0, pulse `bus_err`, go to IDLE, and drop the request.
  - On abort there is no `rf_we`, no `pc_en`, and no `instret` increment.
  - The counter clears on every state change.
- A ready that arrives in the same cycle the counter reaches MEM_TIMEOUT wins: there is no error and the normal transition is taken.
- `run` is ignored outside IDLE. `run` held high at WB-to-IDLE (halt) restarts FETCH on the following cycle.
- A ready input arriving outside its own state is ignored.

## Timing
- Reset (`rst_n`=0, asynchronous): `state`=IDLE, `ctl_q`=0, `taken_q`=0, halt latch=0, wait counter=0, `instret`=0, every output 0.
- Deassertion of `rst_n` is synchronized by the system; the first active edge after it evaluates IDLE.
- Reset asserted mid-operation forces IDLE immediately and drops `im_req`/`dm_req` in the same cycle.
- Latency with zero wait states:
  - Non-memory instruction: 4 cycles (FETCH, DECODE, EXEC, WB).
  - Load or store: 5 cycles.
- Each wait cycle adds 1.
- `run` to first `im_req`: 1 cycle.
- Strobe widths:
  - `alu_en`, `rf_we`, `pc_en`: exactly 1 cycle per instruction.
  - `dm_*` and `im_req`: asserted for the full length of their state.
- All outputs except `ir_en` are functions of registered state only.

## Test plan
- Reset/idle: hold `rst_n`=0 then release with `run`=0 → `state`=0, `busy`=0, all strobes 0, `instret`=0 for 10 cycles.
- ALU instruction, zero wait: `run`=1, `im_ready`=1, flags `RF_w_en`=1 only → states 1,2,3,5,1; `rf_we` and `pc_en` high in cycle 4 with `pc_sel`=0; `instret`=1.
- Load with 3 wait states: flags `DM_r_en`=`Mem2Reg`=`RF_w_en`=1, `dm_ready` high on the 4th MEM cycle → `dm_req`/`dm_re` high for 4 cycles, `dm_we`=0, then WB with `rf_we`=1 and `wb_sel_mem`=1; 8 cycles total.
- Branches:
  - `Branch`=1 with `alu_zero_taken`=1 → `pc_sel`=1 in WB and `rf_we`=0.
  - `Branch`=1 with `alu_zero_taken`=0 → `pc_sel`=0.
  - `is_jal`=1 → `pc_sel`=1 and `rf_we`=1.
- Timeouts, MEM_TIMEOUT=15:
  - `dm_ready` stuck at 0 → `bus_err` pulses exactly once after 15 wait cycles, `state`=0, `instret` unchanged.
  - `dm_ready` arriving on that same cycle → no error.
- Halt and wrap:
  - `halt_req` pulsed during DECODE → the instruction retires and the sequencer returns to IDLE after WB.
  - Preload `instret`=16'hFFFF by running 65535 instructions (or force), retire one more → `instret`=0.

Source files
------------

// File: rtl/ctrl_seq.sv
// Multi-cycle control sequencer for the 8-bit CPU core: steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, owns the memory handshakes and strobes.
module ctrl_seq #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             halt_req,
    input  logic             im_ready,
    input  logic             dm_ready,
    input  logic             Branch,
    input  logic             Mem2Reg,
    input  logic             RF_w_en,
    input  logic             DM_w_en,
    input  logic             DM_r_en,
    input  logic             is_jal,
    input  logic             alu_zero_taken,
    output logic             im_req,
    output logic             ir_en,
    output logic             alu_en,
    output logic             dm_req,
    output logic             dm_we,
    output logic             dm_re,
    output logic             rf_we,
    output logic             wb_sel_mem,
    output logic             pc_en,
    output logic             pc_sel,
    output logic             busy,
    output logic             bus_err,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5
    } state_t;

    // Bit positions inside the latched decoder-flag vector
    localparam int C_JAL = 0;
    localparam int C_DMR = 1;
    localparam int C_DMW = 2;
    localparam int C_RFW = 3;
    localparam int C_M2R = 4;
    localparam int C_BR  = 5;

    localparam logic [7:0] TIMEOUT_C = 8'(MEM_TIMEOUT);

    state_t           state_reg, state_next;
    logic [5:0]       ctl_reg, ctl_next;
    logic             taken_reg, taken_next;
    logic             halt_reg, halt_next;
    logic             bus_err_reg, bus_err_next;
    logic [7:0]       wait_reg, wait_next;
    logic [CNT_W-1:0] instret_reg, instret_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            ctl_reg     <= '0;
            taken_reg   <= 1'b0;
            halt_reg    <= 1'b0;
            bus_err_reg <= 1'b0;
            wait_reg    <= '0;
            instret_reg <= '0;
        end else begin
            state_reg   <= state_next;
            ctl_reg     <= ctl_next;
            taken_reg   <= taken_next;
            halt_reg    <= halt_next;
            bus_err_reg <= bus_err_next;
            wait_reg    <= wait_next;
            instret_reg <= instret_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ctl_next     = ctl_reg;
        taken_next   = taken_reg;
        instret_next = instret_reg;
        bus_err_next = 1'b0;
        case (state_reg)
            S_IDLE: begin
                if (run) state_next = S_FETCH;
            end
            S_FETCH: begin
                // A ready on the last allowed wait cycle still wins over the timeout
                if (im_ready) begin
                    state_next = S_DECODE;
                end else if (wait_reg == TIMEOUT_C) begin
                    state_next   = S_IDLE;
                    bus_err_next = 1'b1;
                end
            end
            S_DECODE: begin
                ctl_next   = {Branch, Mem2Reg, RF_w_en, DM_w_en, DM_r_en, is_jal};
                state_next = S_EXEC;
            end
            S_EXEC: begin
                taken_next = ctl_reg[C_JAL] | (ctl_reg[C_BR] & alu_zero_taken);
                state_next = (ctl_reg[C_DMR] | ctl_reg[C_DMW]) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dm_ready) begin
                    state_next = S_WB;
                end else if (wait_reg == TIMEOUT_C) begin
                    state_next   = S_IDLE;
                    bus_err_next = 1'b1;
                end
            end
            S_WB: begin
                instret_next = instret_reg + 1'b1;
                state_next   = halt_reg ? S_IDLE : S_FETCH;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Wait counter runs only while a handshake is outstanding; any state change clears it
    always_comb begin
        wait_next = wait_reg;
        if (state_next != state_reg) begin
            wait_next = '0;
        end else if ((state_reg == S_FETCH && !im_ready) ||
                     (state_reg == S_MEM && !dm_ready)) begin
            wait_next = wait_reg + 8'd1;
        end
    end

    always_comb begin
        halt_next = halt_reg;
        if (state_next == S_IDLE) begin
            halt_next = 1'b0;
        end else if (state_reg != S_IDLE && halt_req) begin
            halt_next = 1'b1;
        end
    end

    assign im_req     = (state_reg == S_FETCH);
    assign ir_en      = (state_reg == S_FETCH) & im_ready;
    assign alu_en     = (state_reg == S_EXEC);
    assign dm_req     = (state_reg == S_MEM);
    assign dm_we      = (state_reg == S_MEM) & ctl_reg[C_DMW];
    assign dm_re      = (state_reg == S_MEM) & ctl_reg[C_DMR];
    assign rf_we      = (state_reg == S_WB) & ctl_reg[C_RFW];
    assign wb_sel_mem = (state_reg == S_WB) & ctl_reg[C_M2R];
    assign pc_en      = (state_reg == S_WB);
    assign pc_sel     = (state_reg == S_WB) & taken_reg;
    assign busy       = (state_reg != S_IDLE);
    assign bus_err    = bus_err_reg;
    assign state      = state_reg;
    assign instret    = instret_reg;

endmodule

// File: tb/tb_ctrl_seq.sv
// Self-checking bench for ctrl_seq: directed instruction table, hand-written
// reset/halt sequences and randomized instructions against a phase-level model.
module tb_ctrl_seq;

    localparam int TMO = 15;

    localparam logic [5:0] F_BR  = 6'b100000;
    localparam logic [5:0] F_M2R = 6'b010000;
    localparam logic [5:0] F_RF  = 6'b001000;
    localparam logic [5:0] F_DW  = 6'b000100;
    localparam logic [5:0] F_DR  = 6'b000010;
    localparam logic [5:0] F_JAL = 6'b000001;

    logic clk = 1'b0;
    logic rst_n, run, halt_req, im_ready, dm_ready;
    logic Branch, Mem2Reg, RF_w_en, DM_w_en, DM_r_en, is_jal, alu_zero_taken;

    logic im_req, ir_en, alu_en, dm_req, dm_we, dm_re, rf_we, wb_sel_mem;
    logic pc_en, pc_sel, busy, bus_err;
    logic [2:0]  state;
    logic [15:0] instret;

    logic s_im_req, s_ir_en, s_alu_en, s_dm_req, s_dm_we, s_dm_re, s_rf_we, s_wb_sel_mem;
    logic s_pc_en, s_pc_sel, s_busy, s_bus_err;
    logic [2:0] s_state;
    logic [3:0] s_instret;

    ctrl_seq #(.MEM_TIMEOUT(TMO), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .Branch(Branch), .Mem2Reg(Mem2Reg), .RF_w_en(RF_w_en),
        .DM_w_en(DM_w_en), .DM_r_en(DM_r_en), .is_jal(is_jal),
        .alu_zero_taken(alu_zero_taken),
        .im_req(im_req), .ir_en(ir_en), .alu_en(alu_en),
        .dm_req(dm_req), .dm_we(dm_we), .dm_re(dm_re),
        .rf_we(rf_we), .wb_sel_mem(wb_sel_mem), .pc_en(pc_en), .pc_sel(pc_sel),
        .busy(busy), .bus_err(bus_err), .state(state), .instret(instret)
    );

    // Narrow counter copy: exercises the modulo wrap of instret in few cycles
    ctrl_seq #(.MEM_TIMEOUT(TMO), .CNT_W(4)) u_small (
        .clk(clk), .rst_n(rst_n), .run(run), .halt_req(halt_req),
        .im_ready(im_ready), .dm_ready(dm_ready),
        .Branch(Branch), .Mem2Reg(Mem2Reg), .RF_w_en(RF_w_en),
        .DM_w_en(DM_w_en), .DM_r_en(DM_r_en), .is_jal(is_jal),
        .alu_zero_taken(alu_zero_taken),
        .im_req(s_im_req), .ir_en(s_ir_en), .alu_en(s_alu_en),
        .dm_req(s_dm_req), .dm_we(s_dm_we), .dm_re(s_dm_re),
        .rf_we(s_rf_we), .wb_sel_mem(s_wb_sel_mem), .pc_en(s_pc_en), .pc_sel(s_pc_sel),
        .busy(s_busy), .bus_err(s_bus_err), .state(s_state), .instret(s_instret)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0] fl;
        int         fw;
        int         mw;
        logic       zero;
        int         halt_at;
        int         exp_cyc;
        bit         exp_abort;
        bit         exp_idle;
        logic [2:0] exp_wb;   // {rf_we, wb_sel_mem, pc_sel} seen in WB
    } vec_t;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          m_instret;
    bit          m_halt;
    logic [11:0] last_out;

    function automatic logic [11:0] ob(input bit a, b, c, d, e, f, g, h, i, j, k, l);
        return {a, b, c, d, e, f, g, h, i, j, k, l};
    endfunction

    function automatic logic [11:0] dut_out();
        return {im_req, ir_en, alu_en, dm_req, dm_we, dm_re,
                rf_we, wb_sel_mem, pc_en, pc_sel, busy, bus_err};
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Inputs are already driven for this cycle; sample 1ns later, then move to the next negedge
    task automatic expect_cycle(input logic [2:0] es, input logic [11:0] eo, input string nm);
        #1;
        last_out = dut_out();
        check($sformatf("%s.state", nm), 32'(state), 32'(es));
        check($sformatf("%s.outs", nm), 32'(last_out), 32'(eo));
        check($sformatf("%s.instret", nm), 32'(instret), m_instret & 32'hFFFF);
        check($sformatf("%s.instret4", nm), 32'(s_instret), m_instret & 32'hF);
        @(negedge clk);
    endtask

    task automatic rnd_inputs();
        run            = 1'($urandom_range(0, 1));
        halt_req       = 1'b0;
        im_ready       = 1'($urandom_range(0, 1));
        dm_ready       = 1'($urandom_range(0, 1));
        {Branch, Mem2Reg, RF_w_en, DM_w_en, DM_r_en, is_jal} = 6'($urandom);
        alu_zero_taken = 1'($urandom_range(0, 1));
    endtask

    task automatic note_halt(input bit to_idle);
        if (to_idle) m_halt = 1'b0;
        else if (halt_req) m_halt = 1'b1;
    endtask

    task automatic idle_cycle(input bit run_v, input bit berr, input string nm);
        rnd_inputs();
        run      = run_v;
        halt_req = 1'($urandom_range(0, 1));
        expect_cycle(3'd0, ob(0,0,0,0,0,0,0,0,0,0,0,berr), nm);
    endtask

    // Runs one instruction starting at a negedge with the sequencer in FETCH.
    task automatic do_instr(input logic [5:0] fl, input int fw, input int mw, input logic zero,
                            input int halt_at, input bit idle_run, input string nm,
                            output int ncyc, output bit aborted, output bit went_idle,
                            output logic [2:0] wbv);
        int  cyc;
        bit  b, m2r, rfw, dmw, dmr, jal, taken, rdy, ab;
        {b, m2r, rfw, dmw, dmr, jal} = fl;
        cyc = 0; aborted = 0; went_idle = 0; wbv = '0;
        for (int k = 0; k <= TMO && !rdy && !aborted; k++) begin
            rnd_inputs();
            rdy = (k == fw);
            ab  = !rdy && (k == TMO);
            im_ready = rdy;
            halt_req = (cyc == halt_at);
            expect_cycle(3'd1, ob(1,rdy,0,0,0,0,0,0,0,0,1,0), {nm, ".fetch"});
            note_halt(ab);
            cyc++;
            aborted = ab;
        end
        if (!aborted) begin
            rnd_inputs();
            {Branch, Mem2Reg, RF_w_en, DM_w_en, DM_r_en, is_jal} = fl;
            halt_req = (cyc == halt_at);
            expect_cycle(3'd2, ob(0,0,0,0,0,0,0,0,0,0,1,0), {nm, ".decode"});
            note_halt(0); cyc++;

            rnd_inputs();
            alu_zero_taken = zero;
            halt_req = (cyc == halt_at);
            expect_cycle(3'd3, ob(0,0,1,0,0,0,0,0,0,0,1,0), {nm, ".exec"});
            note_halt(0); cyc++;
            taken = jal | (b & zero);

            if (dmr | dmw) begin
                rdy = 0;
                for (int k = 0; k <= TMO && !rdy && !aborted; k++) begin
                    rnd_inputs();
                    rdy = (k == mw);
                    ab  = !rdy && (k == TMO);
                    dm_ready = rdy;
                    halt_req = (cyc == halt_at);
                    expect_cycle(3'd4, ob(0,0,0,1,dmw,dmr,0,0,0,0,1,0), {nm, ".mem"});
                    note_halt(ab);
                    cyc++;
                    aborted = ab;
                end
            end
        end
        if (aborted) begin
            went_idle = 1;
            idle_cycle(idle_run, 1'b1, {nm, ".abort_idle"});
        end else begin
            rnd_inputs();
            halt_req = (cyc == halt_at);
            expect_cycle(3'd5, ob(0,0,0,0,0,0,rfw,m2r,1,taken,1,0), {nm, ".wb"});
            wbv = {last_out[5], last_out[4], last_out[2]};
            went_idle = m_halt;
            note_halt(went_idle);
            m_instret++;
            cyc++;
            if (went_idle) idle_cycle(idle_run, 1'b0, {nm, ".halt_idle"});
        end
        ncyc = cyc;
        $display("instr %s fl=%b fw=%0d mw=%0d cyc=%0d abort=%0b idle=%0b instret=%0d",
                 nm, fl, fw, mw, ncyc, aborted, went_idle, m_instret);
    endtask

    vec_t       vecs[12];
    int         ncyc;
    bit         ab, wi;
    logic [2:0] wbv;

    initial begin
        vecs[0]  = '{F_RF,               0,  0, 1'b0, -1,  4, 1'b0, 1'b0, 3'b100};
        vecs[1]  = '{F_DR | F_M2R | F_RF, 0,  3, 1'b0, -1,  8, 1'b0, 1'b0, 3'b110};
        vecs[2]  = '{F_BR,               0,  0, 1'b1, -1,  4, 1'b0, 1'b0, 3'b001};
        vecs[3]  = '{F_BR,               0,  0, 1'b0, -1,  4, 1'b0, 1'b0, 3'b000};
        vecs[4]  = '{F_JAL | F_RF,       0,  0, 1'b0, -1,  4, 1'b0, 1'b0, 3'b101};
        vecs[5]  = '{F_DW,               2,  0, 1'b1, -1,  7, 1'b0, 1'b0, 3'b000};
        vecs[6]  = '{F_RF,              15,  0, 1'b0, -1, 19, 1'b0, 1'b0, 3'b100};
        vecs[7]  = '{F_DR | F_RF,        0, 99, 1'b0, -1, 19, 1'b1, 1'b1, 3'b000};
        vecs[8]  = '{F_DR | F_RF,        0, 15, 1'b0, -1, 20, 1'b0, 1'b0, 3'b100};
        vecs[9]  = '{F_RF,              99,  0, 1'b0, -1, 16, 1'b1, 1'b1, 3'b000};
        vecs[10] = '{F_RF,               0,  0, 1'b0,  1,  4, 1'b0, 1'b1, 3'b100};
        vecs[11] = '{F_BR | F_JAL,       0,  0, 1'b0, -1,  4, 1'b0, 1'b0, 3'b001};

        rst_n = 1'b0; run = 0; halt_req = 0; im_ready = 0; dm_ready = 0;
        {Branch, Mem2Reg, RF_w_en, DM_w_en, DM_r_en, is_jal} = '0;
        alu_zero_taken = 0;
        m_instret = 0; m_halt = 0;
        @(negedge clk);
        expect_cycle(3'd0, 12'd0, "reset");
        expect_cycle(3'd0, 12'd0, "reset");
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) idle_cycle(1'b0, 1'b0, "idle");
        idle_cycle(1'b1, 1'b0, "start");

        for (int i = 0; i < 12; i++) begin
            do_instr(vecs[i].fl, vecs[i].fw, vecs[i].mw, vecs[i].zero, vecs[i].halt_at,
                     1'b1, $sformatf("tbl%0d", i), ncyc, ab, wi, wbv);
            check($sformatf("tbl%0d.cycles", i), 32'(ncyc), 32'(vecs[i].exp_cyc));
            check($sformatf("tbl%0d.abort", i), 32'(ab), 32'(vecs[i].exp_abort));
            check($sformatf("tbl%0d.idle", i), 32'(wi), 32'(vecs[i].exp_idle));
            if (!vecs[i].exp_abort)
                check($sformatf("tbl%0d.wb", i), 32'(wbv), 32'(vecs[i].exp_wb));
        end

        // Halt raised in EXEC with run low: retire, then park in IDLE
        do_instr(F_RF | F_DR, 0, 1, 1'b0, 2, 1'b0, "halt_park", ncyc, ab, wi, wbv);
        check("halt_park.idle", 32'(wi), 32'd1);
        idle_cycle(1'b0, 1'b0, "parked");
        idle_cycle(1'b0, 1'b0, "parked");
        idle_cycle(1'b1, 1'b0, "restart");

        // Asynchronous reset in the middle of FETCH drops im_req without a clock edge
        rnd_inputs();
        im_ready = 1'b0;
        expect_cycle(3'd1, ob(1,0,0,0,0,0,0,0,0,0,1,0), "pre_rst");
        rnd_inputs();
        im_ready  = 1'b0;
        rst_n     = 1'b0;
        m_instret = 0;
        m_halt    = 0;
        expect_cycle(3'd0, 12'd0, "async_rst");
        rst_n = 1'b1;
        idle_cycle(1'b1, 1'b0, "start2");

        for (int i = 0; i < 400; i++) begin
            logic [5:0] fl;
            int fw, mw, ha;
            bit ir;
            fl = 6'($urandom);
            fw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 2));
            mw = ($urandom_range(0, 15) == 0) ? int'($urandom_range(13, 17)) : int'($urandom_range(0, 2));
            ha = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 6)) : -1;
            ir = ($urandom_range(0, 3) != 0);
            do_instr(fl, fw, mw, 1'($urandom_range(0, 1)), ha, ir,
                     $sformatf("rnd%0d", i), ncyc, ab, wi, wbv);
            if (wi && !ir) idle_cycle(1'b1, 1'b0, "rnd_restart");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
